// File: rtl/cnn_batch_inference_sequencer.sv
// Batch sequencer for the CNN dense layer.
// Runs each image through the external dense layer, reads its NUM_CLASSES
// scores and computes a signed argmax. It streams one result per image over
// a valid/ready interface and has a dense-done watchdog plus abort.
// Optional feature macro: CNN_CONF_MARGIN_EN. When it is defined, the block
// also tracks the second-highest score and drives result_lowconf.
module cnn_batch_inference_sequencer #(
  parameter int NUM_CLASSES = 9,
  parameter int DATA_W      = 32,
  parameter int IMG_W       = 5,
  parameter int CLS_W       = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [IMG_W-1:0]  img_base,
  input  logic [IMG_W-1:0]  img_count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              dense_start,
  output logic [IMG_W-1:0]  dense_img,
  input  logic              dense_done,
  output logic              dense_read_en,
  output logic [CLS_W-1:0]  dense_read_addr,
  input  logic [DATA_W-1:0] dense_read_data,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [CLS_W-1:0]  result_class,
  output logic [IMG_W-1:0]  result_img,
  output logic [DATA_W-1:0] result_score,
  output logic              result_lowconf,
  input  logic [DATA_W-1:0] conf_margin
);
  // The read counter needs one extra bit to reach NUM_CLASSES. That last
  // value is the capture-only cycle.
  localparam int              RD_W    = CLS_W + 1;
  localparam logic [RD_W-1:0] RD_LAST = RD_W'(NUM_CLASSES);
  localparam int              WD_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_START_DENSE, S_WAIT_DENSE, S_READ, S_RESULT, S_FINISH
  } state_t;

  state_t                   r_state, w_next;
  logic [IMG_W-1:0]         r_base, r_count, r_cnt;
  logic [WD_W-1:0]          r_wd;
  logic [RD_W-1:0]          r_rd;
  logic signed [DATA_W-1:0] r_max;
  logic [CLS_W-1:0]         r_cls;
  logic                     r_error, r_zero_done;

  logic             w_accept, w_timeout, w_xfer, w_last_img;
  logic             w_cap, w_first, w_gt;
  logic [CLS_W-1:0] w_idx;
  logic [IMG_W-1:0] w_img;

  assign w_accept   = (r_state == S_IDLE) && start && (img_count != '0);
  assign w_timeout  = (TIMEOUT_CYC != 0) && (r_state == S_WAIT_DENSE) && (r_wd == WD_LAST);
  assign w_xfer     = (r_state == S_RESULT) && result_ready;
  assign w_last_img = (r_cnt == r_count - IMG_W'(1));
  // Data on the bus belongs to the address issued on the previous cycle.
  assign w_cap      = (r_state == S_READ) && (r_rd != '0);
  assign w_first    = (r_rd == RD_W'(1));
  assign w_idx      = r_rd[CLS_W-1:0] - CLS_W'(1);
  assign w_gt       = $signed(dense_read_data) > r_max;
  assign w_img      = r_base + r_cnt;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic. Abort overrides everything except IDLE and FINISH.
  always_comb begin
    w_next = r_state;
    if (abort && (r_state != S_IDLE) && (r_state != S_FINISH)) begin
      w_next = S_FINISH;
    end else begin
      case (r_state)
        S_IDLE:        if (w_accept) w_next = S_START_DENSE;
        S_START_DENSE: w_next = S_WAIT_DENSE;
        S_WAIT_DENSE: begin
          if (dense_done)     w_next = S_READ;
          else if (w_timeout) w_next = S_FINISH;
        end
        S_READ:        if (r_rd == RD_LAST) w_next = S_RESULT;
        S_RESULT:      if (result_ready) w_next = w_last_img ? S_FINISH : S_START_DENSE;
        S_FINISH:      w_next = S_IDLE;
        default:       w_next = S_IDLE;
      endcase
    end
  end

  // Batch bookkeeping, watchdog, read pacing and the error flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_base      <= '0;
      r_count     <= '0;
      r_cnt       <= '0;
      r_wd        <= '0;
      r_rd        <= '0;
      r_error     <= 1'b0;
      r_zero_done <= 1'b0;
    end else begin
      r_zero_done <= (r_state == S_IDLE) && start && (img_count == '0);
      if (w_accept) begin
        r_base  <= img_base;
        r_count <= img_count;
        r_cnt   <= '0;
        r_error <= 1'b0;
      end
      if (w_xfer) r_cnt <= r_cnt + IMG_W'(1);
      if (w_timeout && !dense_done && !abort) r_error <= 1'b1;
      r_wd <= ((r_state == S_WAIT_DENSE) && (TIMEOUT_CYC != 0)) ? r_wd + WD_W'(1) : '0;
      r_rd <= (r_state == S_READ) ? r_rd + RD_W'(1) : '0;
    end
  end

  // Running signed max. A strict compare keeps the lowest index on ties.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_max <= '0;
      r_cls <= '0;
    end else if (w_cap) begin
      if (w_first) begin
        r_max <= $signed(dense_read_data);
        r_cls <= '0;
      end else if (w_gt) begin
        r_max <= $signed(dense_read_data);
        r_cls <= w_idx;
      end
    end
  end

`ifdef CNN_CONF_MARGIN_EN
  logic signed [DATA_W-1:0] r_sec;
  logic [DATA_W:0]          w_margin;

  // Second-highest score. It starts at the most negative value, so the
  // first real sample always displaces it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sec <= '0;
    end else if (w_cap) begin
      if (w_first)                                   r_sec <= {1'b1, {(DATA_W-1){1'b0}}};
      else if (w_gt)                                 r_sec <= r_max;
      else if ($signed(dense_read_data) > r_sec)     r_sec <= $signed(dense_read_data);
    end
  end

  assign w_margin       = {r_max[DATA_W-1], r_max} - {r_sec[DATA_W-1], r_sec};
  assign result_lowconf = (r_state == S_RESULT) && (w_margin < {1'b0, conf_margin});
`else
  logic w_unused_margin;
  assign w_unused_margin = ^conf_margin;
  assign result_lowconf  = 1'b0;
`endif

  assign busy            = (r_state != S_IDLE);
  assign done            = (r_state == S_FINISH) || r_zero_done;
  assign error           = r_error;
  assign dense_start     = (r_state == S_START_DENSE);
  assign dense_img       = w_img;
  assign dense_read_en   = (r_state == S_READ) && (r_rd < RD_LAST);
  assign dense_read_addr = dense_read_en ? r_rd[CLS_W-1:0] : '0;
  assign result_valid    = (r_state == S_RESULT);
  assign result_class    = r_cls;
  assign result_img      = w_img;
  assign result_score    = r_max;

endmodule

// File: tb/tb_cnn_batch_inference_sequencer.sv
// Scoreboard bench for cnn_batch_inference_sequencer.
// A dense-layer responder serves randomized scores. Expected results come
// from a plain argmax model when each batch is issued. A monitor compares
// the model against every offered result.
module tb_cnn_batch_inference_sequencer;
  localparam int N  = 9;
  localparam int DW = 32;
  localparam int IW = 5;
  localparam int CW = 4;
  localparam int TO = 16;

  logic          clk, resetn, start, abort, dense_done, result_ready;
  logic [IW-1:0] img_base, img_count, dense_img, result_img;
  logic [DW-1:0] dense_read_data, conf_margin, result_score;
  logic          busy, done, error, dense_start, dense_read_en, result_valid, result_lowconf;
  logic [CW-1:0] dense_read_addr, result_class;

  typedef struct packed {
    logic [IW-1:0]         img;
    logic [7:0]            d;
    logic                  hang;
    logic [N-1:0][DW-1:0]  sc;
  } stim_t;

  typedef struct packed {
    logic [IW-1:0] img;
    logic [CW-1:0] cls;
    logic [DW-1:0] score;
    logic          lowconf;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    vectors = 0, miscompares = 0, done_cnt = 0, cyc = 0, rdy_mode = 0;
  int    valid_cyc = 0, last_done_cyc = 0;
  logic  last_done_err = 1'b0;
  logic [CW-1:0] last_cls = '0;
  logic [DW-1:0] last_score = '0;
  logic [N-1:0][DW-1:0] dir_sc;

  cnn_batch_inference_sequencer #(
    .NUM_CLASSES(N), .DATA_W(DW), .IMG_W(IW), .CLS_W(CW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .img_base(img_base), .img_count(img_count),
    .abort(abort), .busy(busy), .done(done), .error(error), .dense_start(dense_start),
    .dense_img(dense_img), .dense_done(dense_done), .dense_read_en(dense_read_en),
    .dense_read_addr(dense_read_addr), .dense_read_data(dense_read_data),
    .result_valid(result_valid), .result_ready(result_ready), .result_class(result_class),
    .result_img(result_img), .result_score(result_score), .result_lowconf(result_lowconf),
    .conf_margin(conf_margin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, got, expv);
    end
  endtask

  function automatic logic [63:0] outs_all();
    return 64'({busy, done, error, dense_start, dense_img, dense_read_en, dense_read_addr,
                result_valid, result_class, result_img, result_score, result_lowconf});
  endfunction

  // Reference: the first index holding the largest signed score, plus the
  // gap to the best of the remaining scores.
  function automatic exp_t model(input stim_t s);
    exp_t e;
    int   best;
    best = 0;
    for (int i = 1; i < N; i++)
      if ($signed(s.sc[i]) > $signed(s.sc[best])) best = i;
    e.img   = s.img;
    e.cls   = CW'(best);
    e.score = s.sc[best];
`ifdef CNN_CONF_MARGIN_EN
    begin
      longint mx, sec, v;
      mx  = longint'($signed(s.sc[best]));
      sec = -(longint'(1) <<< 62);
      for (int j = 0; j < N; j++)
        if (j != best) begin
          v = longint'($signed(s.sc[j]));
          if (v > sec) sec = v;
        end
      e.lowconf = ((mx - sec) < longint'(conf_margin));
    end
`else
    e.lowconf = 1'b0;
`endif
    return e;
  endfunction

  function automatic logic [DW-1:0] rnd_score(input int mode);
    if (mode == 0) return DW'($urandom);
    return DW'($urandom_range(0, 6)) - DW'(3);
  endfunction

  task automatic set_dir(input int a[N]);
    for (int k = 0; k < N; k++) dir_sc[k] = DW'(a[k]);
  endtask

  // Queue the per-image stimulus and the expected results, then pulse start.
  task automatic issue(input logic [IW-1:0] base, input logic [IW-1:0] cnt, input int dfix,
                       input int smode, input bit hang, input bit want, output int s);
    stim_t st;
    for (int i = 0; i < int'(cnt); i++) begin
      st.img  = base + IW'(i);
      st.d    = (dfix > 0) ? 8'(dfix) : 8'($urandom_range(1, 12));
      st.hang = hang;
      for (int k = 0; k < N; k++) st.sc[k] = (smode == 2) ? dir_sc[k] : rnd_score(smode);
      stim_q.push_back(st);
      if (want) exp_q.push_back(model(st));
    end
    @(posedge clk); #1;
    start = 1'b1; img_base = base; img_count = cnt; s = cyc;
    @(posedge clk); #1;
    start = 1'b0; img_base = IW'($urandom); img_count = IW'($urandom);
  endtask

  task automatic wait_done(input int prev, input int bound);
    int n;
    n = 0;
    while (done_cnt == prev && n < bound) begin
      @(posedge clk);
      n++;
    end
    chk("done_within_bound", 64'(done_cnt > prev), 64'd1);
  endtask

  // Dense-layer responder: pulses done D cycles after dense_start and
  // returns scores one cycle after each read strobe.
  initial begin
    stim_t         cur;
    int            dd;
    logic          en_s, ds_s;
    logic [CW-1:0] a_s;
    logic [IW-1:0] di_s;
    cur = '0; dd = 0; dense_done = 1'b0; dense_read_data = '0;
    forever begin
      @(negedge clk);
      en_s = dense_read_en; a_s = dense_read_addr; ds_s = dense_start; di_s = dense_img;
      @(posedge clk); #1;
      if (!resetn) begin
        dd = 0;
        dense_done = 1'b0;
      end else begin
        if (ds_s) begin
          if (stim_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_dense_start: got dense_img %0d expected no start", di_s);
          end else begin
            cur = stim_q.pop_front();
            chk("dense_img", 64'(di_s), 64'(cur.img));
            dd = cur.hang ? 0 : int'(cur.d);
          end
        end else if (dd > 0) begin
          dd--;
        end
        dense_done      = (dd == 1);
        dense_read_data = en_s ? cur.sc[a_s] : DW'($urandom);
      end
    end
  end

  // Consumer handshake: 0 = always ready, 1 = stalled, 2 = random.
  initial begin
    result_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       result_ready = 1'b1;
        1:       result_ready = 1'b0;
        default: result_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Monitor: checks every offered result against the scoreboard head and
  // pops the head on the handshake.
  initial begin
    exp_t e;
    logic pv;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        pv = 1'b0;
      end else begin
        if (done) begin
          done_cnt++;
          last_done_cyc = cyc;
          last_done_err = error;
        end
        if (result_valid) begin
          if (!pv) valid_cyc = cyc;
          chk("no_dense_start_while_result", 64'(dense_start), 64'd0);
          if (exp_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_result: got class %0d img %0d expected no result",
                     result_class, result_img);
          end else begin
            e = exp_q[0];
            chk("result_img",     64'(result_img),     64'(e.img));
            chk("result_class",   64'(result_class),   64'(e.cls));
            chk("result_score",   64'(result_score),   64'(e.score));
            chk("result_lowconf", 64'(result_lowconf), 64'(e.lowconf));
            if (result_ready) begin
              e = exp_q.pop_front();
              last_cls   = result_class;
              last_score = result_score;
            end
          end
        end
        pv = result_valid;
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int s, prev, a, n;
    resetn = 1'b0; start = 1'b0; abort = 1'b0; img_base = '0; img_count = '0;
    conf_margin = DW'(3); dir_sc = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", outs_all(), 64'd0);
    resetn = 1'b1;

    // A zero-image batch only produces a done pulse on the next cycle.
    prev = done_cnt;
    issue(5'd4, 5'd0, 0, 0, 1'b0, 1'b0, s);
    wait_done(prev, 10);
    chk("zero_count_done_cyc", 64'(last_done_cyc), 64'(s + 1));

    // Directed image; the tie between indices 2 and 5 goes to 2.
    set_dir('{5, -2, 9, 1, 0, 9, 3, 4, -7});
    prev = done_cnt;
    issue(5'd3, 5'd1, 10, 2, 1'b0, 1'b1, s);
    wait_done(prev, 200);
    chk("single_class",    64'(last_cls),      64'd2);
    chk("single_score",    64'(last_score),    64'd9);
    chk("single_latency",  64'(valid_cyc - s), 64'(10 + N + 3));
    chk("single_done_cyc", 64'(last_done_cyc), 64'(valid_cyc + 1));

    // The image index wraps modulo 2^IMG_W.
    prev = done_cnt;
    issue(5'd30, 5'd4, 0, 0, 1'b0, 1'b1, s);
    wait_done(prev, 500);
    chk("wrap_results_drained", 64'(exp_q.size()), 64'd0);
    chk("wrap_images_started",  64'(stim_q.size()), 64'd0);

    // Back-pressure: the result holds and the next image does not start.
    rdy_mode = 1;
    prev = done_cnt;
    issue(IW'($urandom), 5'd2, 0, 1, 1'b0, 1'b1, s);
    n = 0;
    while (!result_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", 64'(result_valid), 64'd1);
    repeat (20) @(negedge clk);
    chk("bp_second_not_started", 64'(stim_q.size()), 64'd1);
    chk("bp_results_pending",    64'(exp_q.size()),  64'd2);
    rdy_mode = 0;
    wait_done(prev, 300);

    // Randomized batches with a random consumer.
    rdy_mode = 2;
    for (int b = 0; b < 6; b++) begin
      prev = done_cnt;
      issue(IW'($urandom), IW'($urandom_range(1, 5)), 0, int'($urandom_range(0, 1)),
            1'b0, 1'b1, s);
      wait_done(prev, 1000);
    end
    chk("random_drained", 64'(exp_q.size()), 64'd0);
    rdy_mode = 0;

    // Watchdog: dense_done never comes.
    prev = done_cnt;
    issue(5'd7, 5'd2, 0, 0, 1'b1, 1'b0, s);
    wait_done(prev, 100);
    chk("wd_done_cyc",      64'(last_done_cyc), 64'(s + TO + 2));
    chk("wd_error_at_done", 64'(last_done_err), 64'd1);
    @(negedge clk);
    chk("wd_error_sticky",    64'(error),         64'd1);
    chk("wd_no_second_image", 64'(stim_q.size()), 64'd1);
    stim_q.delete();
    prev = done_cnt;
    issue(5'd9, 5'd1, 2, 0, 1'b0, 1'b1, s);
    @(negedge clk);
    chk("wd_error_cleared", 64'(error), 64'd0);
    wait_done(prev, 200);

    // Abort in the middle of READ.
    prev = done_cnt;
    issue(5'd12, 5'd1, 4, 0, 1'b0, 1'b0, s);
    n = 0;
    while (!dense_read_en && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("abort_read_seen", 64'(dense_read_en), 64'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1; a = cyc;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_read_en_off", 64'(dense_read_en), 64'd0);
    chk("abort_done_pulse",  64'(done),          64'd1);
    wait_done(prev, 20);
    chk("abort_done_at", 64'(last_done_cyc), 64'(a + 1));
    @(negedge clk);
    chk("abort_idle", 64'(busy), 64'd0);

    // Asynchronous reset while waiting for the dense layer.
    issue(5'd20, 5'd1, 0, 0, 1'b1, 1'b0, s);
    repeat (4) @(posedge clk);
    #1;
    chk("midwait_busy", 64'(busy), 64'd1);
    resetn = 1'b0;
    #1;
    chk("reset_midwait_outputs", outs_all(), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    stim_q.delete();
    resetn = 1'b1;

    prev = done_cnt;
    issue(IW'($urandom), 5'd3, 0, 0, 1'b0, 1'b1, s);
    wait_done(prev, 500);

    // Score sets aimed at the confidence margin.
    set_dir('{-10, -4, -12, -20, -30, -15, -11, -13, -40});
    prev = done_cnt;
    issue(5'd1, 5'd1, 3, 2, 1'b0, 1'b1, s);
    wait_done(prev, 200);
    chk("neg_class", 64'(last_cls), 64'd1);

    set_dir('{8, 7, 1, 2, 3, -1, 0, 5, 6});
    prev = done_cnt;
    issue(5'd2, 5'd1, 3, 2, 1'b0, 1'b1, s);
    wait_done(prev, 200);
    chk("close_class", 64'(last_cls), 64'd0);

    set_dir('{5, 5, 5, 5, 5, 5, 5, 5, 5});
    prev = done_cnt;
    issue(5'd3, 5'd1, 3, 2, 1'b0, 1'b1, s);
    wait_done(prev, 200);
    chk("equal_class", 64'(last_cls), 64'd0);

    chk("final_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
